// File: rtl/jtag_cmd_engine.sv
// JTAG command engine: decodes synchronised update words, fills/drains the
// ping-pong buffer and programs one of NUM_CH DMA channels.
module jtag_cmd_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BUF_AW     = 8,
  parameter int NUM_CH     = 2,
  parameter int CH_W       = 1
) (
  input  logic                    system_clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  input  logic [3:0]              cmd_opcode,
  input  logic [DATA_WIDTH-1:0]   cmd_payload,
  output logic                    cmd_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    rsp_valid,
  output logic [BUF_AW-1:0]       buf_addr,
  output logic                    buf_we,
  output logic [DATA_WIDTH-1:0]   buf_wdata,
  input  logic [DATA_WIDTH-1:0]   buf_rdata,
  output logic                    buf_switch,
  output logic [NUM_CH-1:0]       dma_launch,
  output logic                    dma_write,
  output logic [ADDR_WIDTH-1:0]   dma_address,
  output logic [DATA_WIDTH/8-1:0] dma_byte_enable,
  output logic [7:0]              dma_burst_size,
  output logic [BUF_AW:0]         dma_block_size,
  input  logic [NUM_CH-1:0]       dma_busy,
  input  logic [NUM_CH-1:0]       dma_done,
  input  logic [BUF_AW:0]         dma_block_size_in,
  output logic                    error
);

  localparam logic [3:0] OP_NOP      = 4'h0;
  localparam logic [3:0] OP_SET_ADDR = 4'h1;
  localparam logic [3:0] OP_SET_BE   = 4'h2;
  localparam logic [3:0] OP_SET_BRST = 4'h3;
  localparam logic [3:0] OP_SET_CH   = 4'h4;
  localparam logic [3:0] OP_GET_ADDR = 4'h5;
  localparam logic [3:0] OP_WR_WORD  = 4'h8;
  localparam logic [3:0] OP_RD_WORD  = 4'h9;
  localparam logic [3:0] OP_LNCH_WR  = 4'hA;
  localparam logic [3:0] OP_LNCH_RD  = 4'hB;
  localparam logic [3:0] OP_SWITCH   = 4'hC;
  localparam logic [3:0] OP_CLEAR    = 4'hE;
  localparam logic [3:0] OP_SRST     = 4'hF;

  localparam logic [BUF_AW:0] DEPTH = {1'b1, {BUF_AW{1'b0}}};

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WAIT_DMA, SWITCH, LAUNCH} state_t;

  state_t                    state, state_nxt;
  logic [BUF_AW:0]           count, count_nxt;
  logic [BUF_AW:0]           rd_ptr, rd_ptr_nxt;
  logic [CH_W-1:0]           ch_sel, ch_sel_nxt;
  logic                      launch_en, launch_en_nxt;
  logic                      error_nxt;
  logic [DATA_WIDTH-1:0]     rsp_data_nxt;
  logic                      rsp_valid_nxt, send_stat;
  logic [BUF_AW-1:0]         buf_addr_nxt;
  logic                      buf_we_nxt;
  logic [DATA_WIDTH-1:0]     buf_wdata_nxt;
  logic                      dma_write_nxt;
  logic [ADDR_WIDTH-1:0]     dma_address_nxt;
  logic [DATA_WIDTH/8-1:0]   dma_byte_enable_nxt;
  logic [7:0]                dma_burst_size_nxt;
  logic [BUF_AW:0]           dma_block_size_nxt;
  logic [BUF_AW:0]           rd_len;
  logic                      soft_rst;

  function automatic logic [DATA_WIDTH-1:0] stat_word(input logic err, input logic busy,
                                                      input logic done, input logic [BUF_AW:0] cnt);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    w[0] = err;
    w[1] = busy;
    w[2] = done;
    w[BUF_AW+3:3] = cnt;
    return w;
  endfunction

  assign soft_rst = reset || (cmd_valid && (cmd_opcode == OP_SRST));
  assign rd_len   = cmd_payload[BUF_AW:0];

  always_comb begin
    state_nxt           = state;
    count_nxt           = count;
    rd_ptr_nxt          = rd_ptr;
    ch_sel_nxt          = ch_sel;
    launch_en_nxt       = launch_en;
    error_nxt           = error;
    rsp_data_nxt        = rsp_data;
    rsp_valid_nxt       = 1'b0;
    send_stat           = 1'b0;
    buf_addr_nxt        = buf_addr;
    buf_we_nxt          = 1'b0;
    buf_wdata_nxt       = buf_wdata;
    dma_write_nxt       = dma_write;
    dma_address_nxt     = dma_address;
    dma_byte_enable_nxt = dma_byte_enable;
    dma_burst_size_nxt  = dma_burst_size;
    dma_block_size_nxt  = dma_block_size;
    cmd_ready           = (state == IDLE);
    buf_switch          = (state == SWITCH);
    dma_launch          = (state == LAUNCH && launch_en) ? (NUM_CH'(1) << ch_sel) : '0;

    case (state)
      IDLE: if (cmd_valid) begin
        send_stat = 1'b1;
        case (cmd_opcode)
          OP_NOP:      ;
          OP_SET_ADDR: dma_address_nxt = cmd_payload[ADDR_WIDTH-1:0];
          OP_SET_BE:   dma_byte_enable_nxt = cmd_payload[DATA_WIDTH/8-1:0];
          OP_SET_BRST: dma_burst_size_nxt = cmd_payload[7:0];
          OP_SET_CH: begin
            if (cmd_payload >= DATA_WIDTH'(NUM_CH)) error_nxt = 1'b1;
            else ch_sel_nxt = cmd_payload[CH_W-1:0];
          end
          OP_GET_ADDR: begin
            send_stat     = 1'b0;
            rsp_valid_nxt = 1'b1;
            rsp_data_nxt  = DATA_WIDTH'(dma_address);
          end
          OP_WR_WORD: begin
            // No wrap: a full buffer rejects further writes.
            if (count < DEPTH) begin
              buf_we_nxt    = 1'b1;
              buf_addr_nxt  = count[BUF_AW-1:0];
              buf_wdata_nxt = cmd_payload;
              count_nxt     = count + (BUF_AW+1)'(1);
            end else begin
              error_nxt = 1'b1;
            end
          end
          OP_RD_WORD: begin
            if (rd_ptr < count) begin
              send_stat    = 1'b0;
              buf_addr_nxt = rd_ptr[BUF_AW-1:0];
              state_nxt    = RD_ADDR;
            end else begin
              error_nxt = 1'b1;
            end
          end
          OP_LNCH_WR: begin
            if (count == '0) begin
              error_nxt = 1'b1;
            end else begin
              send_stat          = 1'b0;
              dma_write_nxt      = 1'b1;
              dma_block_size_nxt = count;
              launch_en_nxt      = 1'b1;
              state_nxt          = WAIT_DMA;
            end
          end
          OP_LNCH_RD: begin
            if (rd_len == '0 || rd_len > DEPTH) begin
              error_nxt = 1'b1;
            end else begin
              send_stat          = 1'b0;
              dma_write_nxt      = 1'b0;
              dma_block_size_nxt = rd_len;
              launch_en_nxt      = 1'b1;
              state_nxt          = WAIT_DMA;
            end
          end
          OP_SWITCH: begin
            send_stat     = 1'b0;
            launch_en_nxt = 1'b0;
            state_nxt     = WAIT_DMA;
          end
          OP_CLEAR: begin
            count_nxt  = '0;
            rd_ptr_nxt = '0;
            error_nxt  = 1'b0;
          end
          OP_SRST: send_stat = 1'b0;
          default: error_nxt = 1'b1;
        endcase
      end
      RD_ADDR: state_nxt = RD_DATA;
      RD_DATA: begin
        rsp_data_nxt  = buf_rdata;
        rsp_valid_nxt = 1'b1;
        rd_ptr_nxt    = rd_ptr + (BUF_AW+1)'(1);
        state_nxt     = IDLE;
      end
      WAIT_DMA: if (!dma_busy[ch_sel]) state_nxt = SWITCH;
      SWITCH: begin
        count_nxt  = dma_block_size_in;
        rd_ptr_nxt = '0;
        state_nxt  = LAUNCH;
      end
      LAUNCH: begin
        send_stat = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Busy engine: anything but a soft reset is dropped and flagged.
    if (cmd_valid && (state != IDLE) && (cmd_opcode != OP_SRST)) error_nxt = 1'b1;

    if (send_stat) begin
      rsp_valid_nxt = 1'b1;
      rsp_data_nxt  = stat_word(error_nxt, dma_busy[ch_sel_nxt], dma_done[ch_sel_nxt], count_nxt);
    end
  end

  always_ff @(posedge system_clk) begin
    if (soft_rst) begin
      state           <= IDLE;
      count           <= '0;
      rd_ptr          <= '0;
      ch_sel          <= '0;
      launch_en       <= 1'b0;
      error           <= 1'b0;
      rsp_data        <= '0;
      rsp_valid       <= 1'b0;
      buf_addr        <= '0;
      buf_we          <= 1'b0;
      buf_wdata       <= '0;
      dma_write       <= 1'b0;
      dma_address     <= '0;
      dma_byte_enable <= '1;
      dma_burst_size  <= '0;
      dma_block_size  <= '0;
    end else begin
      state           <= state_nxt;
      count           <= count_nxt;
      rd_ptr          <= rd_ptr_nxt;
      ch_sel          <= ch_sel_nxt;
      launch_en       <= launch_en_nxt;
      error           <= error_nxt;
      rsp_data        <= rsp_data_nxt;
      rsp_valid       <= rsp_valid_nxt;
      buf_addr        <= buf_addr_nxt;
      buf_we          <= buf_we_nxt;
      buf_wdata       <= buf_wdata_nxt;
      dma_write       <= dma_write_nxt;
      dma_address     <= dma_address_nxt;
      dma_byte_enable <= dma_byte_enable_nxt;
      dma_burst_size  <= dma_burst_size_nxt;
      dma_block_size  <= dma_block_size_nxt;
    end
  end

endmodule

// File: tb/tb_jtag_cmd_engine.sv
// Directed bench for jtag_cmd_engine: a default instance plus a BUF_AW=2
// instance for the buffer-full boundary.
module tb_jtag_cmd_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cmd_valid;
  logic [3:0]  cmd_opcode;
  logic [31:0] cmd_payload;
  logic        cmd_ready;
  logic [31:0] rsp_data;
  logic        rsp_valid;
  logic [7:0]  buf_addr;
  logic        buf_we;
  logic [31:0] buf_wdata;
  logic [31:0] buf_rdata;
  logic        buf_switch;
  logic [1:0]  dma_launch;
  logic        dma_write;
  logic [31:0] dma_address;
  logic [3:0]  dma_byte_enable;
  logic [7:0]  dma_burst_size;
  logic [8:0]  dma_block_size;
  logic [1:0]  dma_busy;
  logic [1:0]  dma_done;
  logic [8:0]  dma_block_size_in;
  logic        error;

  logic        s_cmd_valid;
  logic [3:0]  s_cmd_opcode;
  logic [31:0] s_cmd_payload;
  logic        s_cmd_ready;
  logic [31:0] s_rsp_data;
  logic        s_rsp_valid;
  logic [1:0]  s_buf_addr;
  logic        s_buf_we;
  logic [31:0] s_buf_wdata;
  logic        s_buf_switch;
  logic [1:0]  s_dma_launch;
  logic        s_dma_write;
  logic [31:0] s_dma_address;
  logic [3:0]  s_dma_byte_enable;
  logic [7:0]  s_dma_burst_size;
  logic [2:0]  s_dma_block_size;
  logic        s_error;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:255];

  jtag_cmd_engine dut (
    .system_clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode),
    .cmd_payload(cmd_payload), .cmd_ready(cmd_ready), .rsp_data(rsp_data), .rsp_valid(rsp_valid),
    .buf_addr(buf_addr), .buf_we(buf_we), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
    .buf_switch(buf_switch), .dma_launch(dma_launch), .dma_write(dma_write),
    .dma_address(dma_address), .dma_byte_enable(dma_byte_enable), .dma_burst_size(dma_burst_size),
    .dma_block_size(dma_block_size), .dma_busy(dma_busy), .dma_done(dma_done),
    .dma_block_size_in(dma_block_size_in), .error(error)
  );

  jtag_cmd_engine #(.BUF_AW(2)) dut_s (
    .system_clk(clk), .reset(reset), .cmd_valid(s_cmd_valid), .cmd_opcode(s_cmd_opcode),
    .cmd_payload(s_cmd_payload), .cmd_ready(s_cmd_ready), .rsp_data(s_rsp_data),
    .rsp_valid(s_rsp_valid), .buf_addr(s_buf_addr), .buf_we(s_buf_we), .buf_wdata(s_buf_wdata),
    .buf_rdata(32'h0), .buf_switch(s_buf_switch), .dma_launch(s_dma_launch),
    .dma_write(s_dma_write), .dma_address(s_dma_address), .dma_byte_enable(s_dma_byte_enable),
    .dma_burst_size(s_dma_burst_size), .dma_block_size(s_dma_block_size), .dma_busy(2'b00),
    .dma_done(2'b00), .dma_block_size_in(3'd0), .error(s_error)
  );

  // Buffer memory with one-cycle read latency.
  always @(posedge clk) begin
    if (buf_we) mem[buf_addr] <= buf_wdata;
    buf_rdata <= mem[buf_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [3:0] op, input logic [31:0] pl);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_payload = pl;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic cmd_s(input logic [3:0] op, input logic [31:0] pl);
    @(negedge clk);
    s_cmd_valid = 1'b1; s_cmd_opcode = op; s_cmd_payload = pl;
    @(negedge clk);
    s_cmd_valid = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] idx, input logic [31:0] exp);
    cmd(4'h9, 32'h0);
    chk({tag, "_t1_vld"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_t1_busy"}, 64'(cmd_ready), 64'd0);
    chk({tag, "_t1_addr"}, 64'(buf_addr), 64'(idx));
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_t3_vld"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_t3_data"}, 64'(rsp_data), 64'(exp));
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_opcode = 4'h0; cmd_payload = 32'h0;
    s_cmd_valid = 1'b0; s_cmd_opcode = 4'h0; s_cmd_payload = 32'h0;
    dma_busy = 2'b00; dma_done = 2'b00; dma_block_size_in = 9'd7;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_be", 64'(dma_byte_enable), 64'hF);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_launch", 64'(dma_launch), 64'd0);
    chk("rst_blk", 64'(dma_block_size), 64'd0);
    reset = 1'b0;

    // Buffer writes
    cmd(4'h8, 32'hA5A5A5A5);
    chk("wr0_we", 64'(buf_we), 64'd1);
    chk("wr0_addr", 64'(buf_addr), 64'd0);
    chk("wr0_data", 64'(buf_wdata), 64'hA5A5A5A5);
    chk("wr0_rsp", 64'(rsp_data), 64'h08);
    cmd(4'h8, 32'h12345678);
    chk("wr1_we", 64'(buf_we), 64'd1);
    chk("wr1_addr", 64'(buf_addr), 64'd1);
    chk("wr1_rsp", 64'(rsp_data), 64'h10);
    cmd(4'h0, 32'h0);
    chk("nop_stat", 64'(rsp_data), 64'h10);
    chk("nop_we", 64'(buf_we), 64'd0);

    // Buffer reads, third one underflows
    rd("rd0", 8'd0, 32'hA5A5A5A5);
    rd("rd1", 8'd1, 32'h12345678);
    cmd(4'h9, 32'h0);
    chk("rd2_vld", 64'(rsp_valid), 64'd1);
    chk("rd2_stat", 64'(rsp_data), 64'h11);
    chk("rd2_err", 64'(error), 64'd1);
    chk("rd2_ready", 64'(cmd_ready), 64'd1);
    cmd(4'hE, 32'h0);
    chk("clr_stat", 64'(rsp_data), 64'h0);
    chk("clr_err", 64'(error), 64'd0);

    // Small buffer: fifth write rejected
    for (int i = 0; i < 4; i++) begin
      cmd_s(4'h8, 32'h100 + 32'(i));
      chk("s_wr_we", 64'(s_buf_we), 64'd1);
      chk("s_wr_addr", 64'(s_buf_addr), 64'(i));
      chk("s_wr_rsp", 64'(s_rsp_data), 64'((i + 1) * 8));
    end
    cmd_s(4'h8, 32'h999);
    chk("s_wr4_we", 64'(s_buf_we), 64'd0);
    chk("s_wr4_err", 64'(s_error), 64'd1);
    chk("s_wr4_rsp", 64'(s_rsp_data), 64'h21);
    cmd_s(4'h0, 32'h0);
    chk("s_nop_rsp", 64'(s_rsp_data), 64'h21);

    // Launch on channel 1 behind a busy channel
    cmd(4'h8, 32'h1); cmd(4'h8, 32'h2); cmd(4'h8, 32'h3);
    dma_busy = 2'b10;
    cmd(4'h4, 32'd1);
    chk("setch_rsp", 64'(rsp_data), 64'h1A);
    cmd(4'h1, 32'h1000);
    cmd(4'h5, 32'h0);
    chk("getaddr", 64'(rsp_data), 64'h1000);
    cmd(4'hA, 32'h0);
    chk("lw_ready", 64'(cmd_ready), 64'd0);
    chk("lw_write", 64'(dma_write), 64'd1);
    chk("lw_blk", 64'(dma_block_size), 64'd3);
    repeat (8) @(negedge clk);
    chk("lw_hold_sw", 64'(buf_switch), 64'd0);
    chk("lw_hold_ln", 64'(dma_launch), 64'd0);
    dma_busy = 2'b00;
    @(negedge clk);
    chk("lw_switch", 64'(buf_switch), 64'd1);
    chk("lw_sw_launch", 64'(dma_launch), 64'd0);
    @(negedge clk);
    chk("lw_launch", 64'(dma_launch), 64'b10);
    chk("lw_sw_off", 64'(buf_switch), 64'd0);
    chk("lw_addr", 64'(dma_address), 64'h1000);
    chk("lw_blk2", 64'(dma_block_size), 64'd3);
    @(negedge clk);
    chk("lw_done_vld", 64'(rsp_valid), 64'd1);
    chk("lw_done_stat", 64'(rsp_data), 64'h38);
    chk("lw_done_ln", 64'(dma_launch), 64'd0);
    chk("lw_done_rdy", 64'(cmd_ready), 64'd1);

    // Invalid channel leaves ch_sel at 1
    cmd(4'h4, 32'd2);
    chk("badch_err", 64'(error), 64'd1);
    chk("badch_rsp", 64'(rsp_data), 64'h39);
    dma_done = 2'b10;
    cmd(4'h0, 32'h0);
    chk("badch_keep", 64'(rsp_data), 64'h3D);
    dma_done = 2'b00;
    cmd(4'hE, 32'h0);
    chk("clr2_rsp", 64'(rsp_data), 64'h0);
    chk("clr2_err", 64'(error), 64'd0);

    // LAUNCH_READ length bounds and an unknown opcode
    cmd(4'hB, 32'h0);
    chk("lr0_err", 64'(error), 64'd1);
    chk("lr0_ready", 64'(cmd_ready), 64'd1);
    cmd(4'hE, 32'h0);
    cmd(4'hB, 32'h101);
    chk("lr257_err", 64'(error), 64'd1);
    chk("lr257_ready", 64'(cmd_ready), 64'd1);
    cmd(4'hE, 32'h0);
    cmd(4'h7, 32'h0);
    chk("badop_err", 64'(error), 64'd1);
    cmd(4'hE, 32'h0);

    // Soft reset aborts a pending launch
    dma_busy = 2'b10;
    cmd(4'hB, 32'd4);
    chk("lr_write", 64'(dma_write), 64'd0);
    chk("lr_blk", 64'(dma_block_size), 64'd4);
    chk("lr_ready", 64'(cmd_ready), 64'd0);
    cmd(4'h0, 32'h0);
    chk("drop_err", 64'(error), 64'd1);
    chk("drop_vld", 64'(rsp_valid), 64'd0);
    cmd(4'hF, 32'h0);
    chk("srst_ready", 64'(cmd_ready), 64'd1);
    chk("srst_err", 64'(error), 64'd0);
    chk("srst_blk", 64'(dma_block_size), 64'd0);
    chk("srst_addr", 64'(dma_address), 64'd0);
    chk("srst_be", 64'(dma_byte_enable), 64'hF);
    chk("srst_rsp", 64'(rsp_data), 64'd0);
    chk("srst_vld", 64'(rsp_valid), 64'd0);
    dma_busy = 2'b00;
    repeat (3) @(negedge clk);
    chk("srst_no_launch", 64'(dma_launch), 64'd0);
    chk("srst_no_switch", 64'(buf_switch), 64'd0);
    cmd(4'hA, 32'h0);
    chk("lw_empty_err", 64'(error), 64'd1);
    chk("lw_empty_rdy", 64'(cmd_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtag_cmd_engine.md
Name: jtag_cmd_engine

Overview:
- Parametrised, multi-channel successor to the JTAG chain-1 command decoder.
- Runs entirely in the system clock domain and consumes already-synchronised JTAG update words (opcode + payload).
- Fills and drains the ping-pong buffer and programs the DMA.
- Launches transfers on one of NUM_CH DMA channels and returns a capture word for the next JTAG shift.
- Adds over chain 1: channel select, configurable data/buffer widths, a sticky error flag, and a defined response for every command.

Parameters:
- DATA_WIDTH, 32: buffer word and payload width; must be >= BUF_AW+4 and >= ADDR_WIDTH.
- ADDR_WIDTH, 32: DMA address width.
- BUF_AW, 8: buffer depth is 2^BUF_AW words.
- NUM_CH, 2: number of DMA channels.
- CH_W, 1: channel-select width; 2^CH_W >= NUM_CH.

Ports:
- system_clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  one-cycle command strobe.
- cmd_opcode  in  4  command code.
- cmd_payload  in  DATA_WIDTH  command argument.
- cmd_ready  out  1  high only in IDLE.
- rsp_data  out  DATA_WIDTH  capture word for the next shift.
- rsp_valid  out  1  one-cycle pulse when rsp_data is updated.
- buf_addr  out  BUF_AW  buffer word address (registered).
- buf_we  out  1  buffer write enable.
- buf_wdata  out  DATA_WIDTH  buffer write data.
- buf_rdata  in  DATA_WIDTH  buffer read data; valid 1 cycle after buf_addr.
- buf_switch  out  1  one-cycle ping-pong swap pulse.
- dma_launch  out  NUM_CH  one-hot, one-cycle launch pulse.
- dma_write  out  1  1 = buffer-to-memory transfer, 0 = memory-to-buffer.
- dma_address  out  ADDR_WIDTH  transfer start address.
- dma_byte_enable  out  DATA_WIDTH/8  byte lanes.
- dma_burst_size  out  8  burst length.
- dma_block_size  out  BUF_AW+1  transfer size in words.
- dma_busy  in  NUM_CH  per-channel busy.
- dma_done  in  NUM_CH  per-channel done.
- dma_block_size_in  in  BUF_AW+1  fill level of the buffer half being swapped in.
- error  out  1  sticky error flag.

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1 and dma_byte_enable=all ones. Internal count, rd_ptr and ch_sel are 0; FSM is in IDLE.
- Status word (STAT), zero-extended to DATA_WIDTH:
  - bit0 error
  - bit1 dma_busy[ch_sel]
  - bit2 dma_done[ch_sel]
  - bits[BUF_AW+3:3] count
- Command accepted when cmd_valid && cmd_ready, at cycle T. Register updates are visible at T+1.
- Simple commands: rsp_data updated and rsp_valid=1 at T+1; rsp_data=STAT unless stated otherwise.
- cmd_valid while cmd_ready=0: command dropped, error set. Opcode 0xF is the only exception.
- Opcodes:
  - 0x0 NOP.
  - 0x1 SET_ADDR: address <= payload[ADDR_WIDTH-1:0].
  - 0x2 SET_BE.
  - 0x3 SET_BURST: payload[7:0].
  - 0x4 SET_CH: if payload >= NUM_CH, error and ch_sel unchanged.
  - 0x5 GET_ADDR: rsp_data = address.
  - 0x8 WRITE_WORD: if count < 2^BUF_AW, then buf_we=1, buf_addr=count[BUF_AW-1:0] and buf_wdata=payload at T+1, and count++. Otherwise error with no write (no wrap).
  - 0x9 READ_WORD:
    - If rd_ptr < count: enter RD_ADDR at T+1 with buf_addr=rd_ptr, then RD_DATA at T+2 capturing buf_rdata. IDLE at T+3 with rsp_data=captured word, rsp_valid=1, rd_ptr++.
    - Otherwise error, with STAT returned at T+1.
  - 0xA LAUNCH_WRITE: count==0 → error. Otherwise dma_write=1, dma_block_size=count, go to WAIT_DMA.
  - 0xB LAUNCH_READ: payload[BUF_AW:0]==0 or > 2^BUF_AW → error. Otherwise dma_write=0, dma_block_size=payload, go to WAIT_DMA.
  - 0xC SWITCH_ONLY: go to WAIT_DMA with no launch pulse.
  - 0xE CLEAR: count=0, rd_ptr=0, error=0.
  - 0xF SOFT_RESET: accepted in any state; identical to reset (aborts the operation, no buf_switch/dma_launch).
  - Any other opcode sets error.
- Launch FSM, IDLE → WAIT_DMA → SWITCH → LAUNCH → IDLE:
  - WAIT_DMA holds while dma_busy[ch_sel]=1.
  - SWITCH: buf_switch=1; count <= dma_block_size_in; rd_ptr <= 0.
  - LAUNCH: dma_launch[ch_sel]=1, except for SWITCH_ONLY.
  - Return to IDLE with rsp_data=STAT and rsp_valid=1.
  - dma_address, dma_burst_size, dma_byte_enable, dma_write and dma_block_size stay stable from WAIT_DMA until the next launch command.
- Error commands never change state other than the error bit.

Test Plan:
- Reset; WRITE_WORD 0xA5A5A5A5, 0x12345678 → buf_we at addr 0 then 1; STAT count=2, error=0.
- Write 2 words, READ_WORD ×3 → rsp_valid at T+3 with 0xA5A5A5A5 then 0x12345678; third read sets error, rsp=STAT.
- BUF_AW=2: 5 WRITE_WORDs → 4 writes, 5th sets error, count stays 4, no buf_we.
- SET_CH 1, SET_ADDR 0x1000, dma_busy[1]=1 for 10 cycles, LAUNCH_WRITE with count 3 → buf_switch 1 cycle after busy drops, then dma_launch=2'b10, dma_block_size=3, dma_address=0x1000; count=dma_block_size_in afterwards.
- SET_CH 2 with NUM_CH=2 → error=1, ch_sel unchanged. CLEAR → error=0, count=0.
- LAUNCH_READ 4 while busy held, then NOP (dropped, error=1), then SOFT_RESET → FSM IDLE, no dma_launch, all outputs at reset values.
